sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised synchronous FIFO: generalises the fixed 8-entry, 3-bit-pointer buffer to any power-of-two depth and any data width. Every one of the DEPTH entries is usable. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe and optional overflow/underflow error pulses. It sits between a single-clock producer and consumer wherever the design needs elastic buffering.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_THRESH`, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- `AE_THRESH`, 2: almost_empty asserts when count ≤ AE_THRESH.
- Derived, not overridable: AW = $clog2(DEPTH); count width CW = AW+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `w_en` in 1: write request.
- `w_data_ip` in WIDTH: write data.
- `r_en` in 1: read request.
- `r_data_op` out WIDTH: registered read data.
- `r_valid` out 1: one-cycle strobe; r_data_op was updated by an accepted read.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `almost_empty` out 1: count ≤ AE_THRESH.
- `almost_full` out 1: count ≥ AF_THRESH.
- `count` out CW: current occupancy, 0..DEPTH.
- `overflow` out 1: one-cycle pulse; write rejected.
- `underflow` out 1: one-cycle pulse; read rejected.

## Operation
- Pointers: w_ptr and r_ptr are AW+1 bits each. Address = ptr[AW-1:0].
  - empty = (w_ptr == r_ptr).
  - full = MSBs differ and lower AW bits are equal.
  - count = w_ptr − r_ptr, modulo 2^(AW+1).
- Pointer wrap is natural binary roll-over; there is no special case at DEPTH-1.
- Write accepted = w_en & ~full, with full taken as its pre-edge value. On acceptance: mem[w_addr] ← w_data_ip and w_ptr += 1.
- Read accepted = r_en & ~empty, with empty taken as its pre-edge value. On acceptance: r_data_op ← mem[r_addr], r_ptr += 1, and r_valid = 1 for the next cycle.
- When no read is accepted: r_data_op holds its last value and r_valid = 0.
- Simultaneous w_en & r_en:
  - Not empty and not full: both are accepted and count is unchanged.
  - Full: the read is accepted; the write is rejected (overflow path).
  - Empty: the write is accepted; the read is rejected (underflow path). There is no write-through bypass.
- Rejected write: memory and w_ptr are unchanged.
- Rejected read: r_data_op and r_ptr are unchanged.
- Reset (asynchronous, any time, including mid-transfer) forces the following immediately; the memory array is not reset:
  - w_ptr = 0, r_ptr = 0, count = 0
  - r_data_op = 0, r_valid = 0
  - empty = 1, full = 0, almost_full = 0
  - almost_empty = 1
  - overflow = 0, underflow = 0
- Status outputs (empty, full, almost_*, count) are combinational decodes of the registered pointers. They change only after a clock edge or on reset.

## Timing
- Write-to-read latency: write accepted at edge N; empty = 0 after edge N; r_en sampled at edge N+1 returns the data on r_data_op with r_valid = 1 in the cycle after edge N+1.
- Read latency: 1 cycle from the accepting edge to r_data_op/r_valid.
- Sustained throughput: 1 write and 1 read per cycle when neither full nor empty.
- Flags update in the same cycle as count, one edge after the causing transfer.
- overflow/underflow are registered and asserted for exactly the one cycle after the rejecting edge.

## Configuration
- Macro: `SYNC_FIFO_ERR_EN`.
- Defined: overflow is set for one cycle after each edge with w_en & full. underflow is set for one cycle after each edge with r_en & empty.
- Undefined: overflow and underflow are tied to 0 and no error logic is synthesised. All other behaviour is identical.

## Test plan
- Reset then fill: with WIDTH=8, DEPTH=16, write 0x00..0x0F on 16 consecutive cycles.
  - full = 1 and count = 16 after the 16th edge.
  - almost_full rises after the 14th write (count = 14).
- Drain: read 16 times from full → r_data_op = 0x00..0x0F in order, r_valid high for 16 cycles. empty = 1 and count = 0 afterwards; almost_empty rises at count = 2.
- Wrap: write 10, read 10, then write 12 and read 12 → the data comes back in order across the pointer roll-over, with no false full or false empty.
- Boundaries (ERR_EN defined):
  - Write while full → overflow pulses for 1 cycle; contents and count are unchanged.
  - Read while empty → underflow pulses for 1 cycle; r_data_op holds and r_valid = 0.
  - w_en & r_en while full → the read returns the oldest entry, count = 15, overflow = 1.
- Simultaneous read/write at count = 5 for 20 cycles → count stays 5 and the data order is preserved.
- Asynchronous rst asserted mid-burst, between edges → all outputs take their reset values immediately, without waiting for a clock edge. After release, the first write/read pair returns the new data.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags and a read-valid strobe. Define SYNC_FIFO_ERR_EN to add registered overflow/underflow pulses.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       w_data_ip,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       r_data_op,
  output logic                   r_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_LEVEL = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    w_ptr;
  logic [CW-1:0]    r_ptr;
  logic [AW-1:0]    w_addr;
  logic [AW-1:0]    r_addr;
  logic             w_ok;
  logic             r_ok;

  assign w_addr = w_ptr[AW-1:0];
  assign r_addr = r_ptr[AW-1:0];

  // The extra pointer MSB distinguishes a full buffer from an empty one when addresses match.
  assign empty        = (w_ptr == r_ptr);
  assign full         = (w_ptr[AW] != r_ptr[AW]) && (w_addr == r_addr);
  assign count        = w_ptr - r_ptr;
  assign almost_empty = (count <= AE_LEVEL);
  assign almost_full  = (count >= AF_LEVEL);

  assign w_ok = w_en & ~full;
  assign r_ok = r_en & ~empty;

  // NOTE: non-blocking assignments so every register samples pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      r_data_op <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= r_ok;
      if (w_ok) begin
        w_ptr <= w_ptr + CW'(1);
      end
      if (r_ok) begin
        r_ptr     <= r_ptr + CW'(1);
        r_data_op <= mem[r_addr];
      end
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_ok) begin
      mem[w_addr] <= w_data_ip;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= w_en & full;
      underflow <= r_en & empty;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed and randomised traffic compared
// against a queue-based reference model of the FIFO's behaviour.
module tb_sync_fifo_flags;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             w_en;
  logic [WIDTH-1:0] w_data_ip;
  logic             r_en;
  logic [WIDTH-1:0] r_data_op;
  logic             r_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rdata;
  bit               m_rv;
  bit               m_ovf;
  bit               m_udf;

  sync_fifo_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data_ip(w_data_ip), .r_en(r_en),
    .r_data_op(r_data_op), .r_valid(r_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("r_data_op",    r_data_op,    m_rdata);
    check("r_valid",      r_valid,      m_rv);
    check("empty",        empty,        n == 0);
    check("full",         full,         n == DEPTH);
    check("almost_empty", almost_empty, n <= AE);
    check("almost_full",  almost_full,  n >= AF);
    check("count",        count,        n);
    check("overflow",     overflow,     m_ovf);
    check("underflow",    underflow,    m_udf);
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_rv    = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock cycle: drive requests, apply the FIFO rules to the model at the edge, then compare.
  task automatic step(input bit we, input logic [WIDTH-1:0] wd, input bit re);
    int n;
    w_en      = we;
    w_data_ip = wd;
    r_en      = re;
    @(posedge clk);
    n     = q.size();
    m_ovf = ERR_EN && we && (n == DEPTH);
    m_udf = ERR_EN && re && (n == 0);
    m_rv  = re && (n != 0);
    if (m_rv) m_rdata = q.pop_front();
    if (we && (n != DEPTH)) q.push_back(wd);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    check_all();
  endtask

  initial begin
    rst       = 1'b1;
    w_en      = 1'b0;
    r_en      = 1'b0;
    w_data_ip = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0x00..0x0F, then errors at full, then drain through empty.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, '0, 1'b1);

    // Pointer roll-over.
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    // Steady simultaneous traffic at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Random traffic, first biased toward writes then toward reads.
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0);

    // Asynchronous reset between edges in the middle of a burst.
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), i > 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, '0, 1'b1);
    check("post_reset_data", r_data_op, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
